// File: rtl/set_bit_index_streamer_pkg.sv
// Shared types and width helpers for set_bit_index_streamer.
// Width localparams are derived from the word width through the helper functions.
package set_bit_index_streamer_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    function automatic int unsigned idx_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned IDX_W = idx_w(WIDTH_DEF);
    localparam int unsigned CNT_W = cnt_w(WIDTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/set_bit_index_streamer_if.sv
// Word-in / index-out handshake bundle for set_bit_index_streamer.
// The slave modport is the streamer; the master modport is producer plus consumer.
interface set_bit_index_streamer_if
    import set_bit_index_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0]          data_i;
    logic                      data_val_i;
    logic                      data_ready_o;
    logic [idx_w(WIDTH)-1:0]   idx_o;
    logic                      idx_val_o;
    logic                      idx_ready_i;
    logic                      idx_last_o;
    logic                      zero_o;
    logic [cnt_w(WIDTH)-1:0]   cnt_o;

    modport slave (
        input  data_i,
        input  data_val_i,
        output data_ready_o,
        output idx_o,
        output idx_val_o,
        input  idx_ready_i,
        output idx_last_o,
        output zero_o,
        output cnt_o
    );

    modport master (
        output data_i,
        output data_val_i,
        input  data_ready_o,
        input  idx_o,
        input  idx_val_o,
        output idx_ready_i,
        input  idx_last_o,
        input  zero_o,
        input  cnt_o
    );

endinterface

// File: rtl/set_bit_index_streamer_lsb_priority_encoder.sv
// Combinational LSB-first priority encoder: lowest set index, any-set and
// exactly-one-set flags for the pending mask.
module lsb_priority_encoder
    import set_bit_index_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]        i_mask,
    output logic [idx_w(WIDTH)-1:0] o_idx,
    output logic                    o_any,
    output logic                    o_single
);

    localparam int unsigned IDXW = idx_w(WIDTH);

    logic [WIDTH-1:0] w_mask_dec;

    // Scan from MSB down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (i_mask[i-1]) begin
                o_idx = IDXW'(i - 1);
            end
        end
    end

    always_comb begin
        w_mask_dec = i_mask - WIDTH'(1);
        o_any      = |i_mask;
        o_single   = o_any && ((i_mask & w_mask_dec) == '0);
    end

endmodule

// File: rtl/set_bit_index_streamer.sv
// Expands an accepted word into one beat per set bit, LSB first, each tagged
// with its running ordinal; an all-zero word yields a single zero beat.
module set_bit_index_streamer
    import set_bit_index_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    set_bit_index_streamer_if.slave       bus
);

    localparam int unsigned IDXW = idx_w(WIDTH);
    localparam int unsigned CNTW = cnt_w(WIDTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  w_mask_next;
    logic [CNTW-1:0]   r_ord;
    logic [CNTW-1:0]   w_ord_next;

    logic [IDXW-1:0]   w_enc_idx;
    logic              w_any;
    logic              w_single;
    logic              w_emit;
    logic              w_last;
    logic              w_beat;
    logic [WIDTH-1:0]  w_clr;

    lsb_priority_encoder #(
        .WIDTH (WIDTH)
    ) u_enc (
        .i_mask   (r_mask),
        .o_idx    (w_enc_idx),
        .o_any    (w_any),
        .o_single (w_single)
    );

    always_comb begin
        w_emit = (r_state == EMIT);
        w_last = w_emit && (w_single || !w_any);
        w_beat = w_emit && bus.idx_ready_i;
        w_clr  = WIDTH'(1) << w_enc_idx;
    end

    // Beat outputs depend only on registered state; gating by EMIT keeps
    // the idle/reset view at all-zero even though an empty mask encodes as zero.
    always_comb begin
        bus.data_ready_o = !w_emit;
        bus.idx_val_o    = w_emit;
        bus.idx_o        = w_emit ? w_enc_idx : '0;
        bus.zero_o       = w_emit && !w_any;
        bus.idx_last_o   = w_last;
        bus.cnt_o        = (w_emit && w_any) ? r_ord : '0;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ordinal is not advanced on the final beat, so it tops out at WIDTH.
    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_ord_next   = r_ord;
        unique case (r_state)
            IDLE: begin
                if (bus.data_val_i) begin
                    w_mask_next  = bus.data_i;
                    w_ord_next   = CNTW'(1);
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (w_beat) begin
                    w_mask_next = r_mask & ~w_clr;
                    if (w_last) begin
                        w_state_next = IDLE;
                    end else begin
                        w_ord_next = r_ord + CNTW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_mask <= '0;
            r_ord  <= '0;
        end else begin
            r_mask <= w_mask_next;
            r_ord  <= w_ord_next;
        end
    end

    a_stall_stable: assert property (
        @(posedge clk_i) disable iff (!arst_n_i)
        (bus.idx_val_o && !bus.idx_ready_i) |=>
            ($stable(bus.idx_o) && $stable(bus.cnt_o) &&
             $stable(bus.idx_last_o) && $stable(bus.zero_o))
    );

    a_cnt_bound: assert property (
        @(posedge clk_i) disable iff (!arst_n_i)
        int'(bus.cnt_o) <= int'(WIDTH)
    );

endmodule
